spram_arbiter: RTL and testbench
================================

// Module: spram_arbiter
// PURPOSE
//   Shares one single_port_ram instance between two requesters (A, B) using round-robin arbitration.
//   Sequences the RAM's cs / wr_rd / out_en / address / data_in pins and captures the RAM's tristated data_out.
//   Returns a one-cycle done pulse, with read data, to the requester that owns the transaction.
//   Sits between bus-side masters (e.g. DMA and CPU port) and the RAM macro.
// PARAMETERS
//   data_width  8   RAM word width; must match the attached RAM
//   addr_size   4   address bits
//   mem_depth   16  implemented words; addresses >= mem_depth are errors
// PORTS
//   clk          in   1           single clock; all state updates on posedge
//   rst          in   1           asynchronous, active-high reset
//   a_req        in   1           requester A: transaction valid; held until a_gnt
//   a_wr         in   1           1 = write, 0 = read
//   a_addr       in   addr_size   word address
//   a_wdata      in   data_width  write data
//   a_gnt        out  1           accept strobe; combinational
//   a_done       out  1           1-cycle completion pulse
//   a_rdata      out  data_width  read data; valid while a_done=1
//   a_err        out  1           out-of-range address; valid while a_done=1
//   b_*          --   --          identical port set for requester B
//   ram_cs       out  1           to RAM cs
//   ram_wr_rd    out  1           to RAM wr_rd (1 = write)
//   ram_out_en   out  1           to RAM out_en
//   ram_address  out  addr_size   to RAM address
//   ram_data_in  out  data_width  to RAM data_in
//   ram_data_out in   data_width  from RAM data_out (Z when not enabled)
// BEHAVIOUR
//   FSM states: IDLE, ACCESS, RDOUT, DONE.
//   IDLE
//     - x_gnt = x_req & winner.
//     - On grant, latch wr/addr/wdata and the owner; update last_owner; go to ACCESS.
//     - Requests not granted in a cycle are never accepted in that cycle.
//   Arbitration
//     - Only one requesting: that requester wins.
//     - Both requesting: the one that is not last_owner wins.
//     - last_owner resets to B, so A wins the first tie.
//   ACCESS
//     - ram_cs=1, ram_wr_rd=latched wr, ram_address=latched addr, ram_data_in=latched wdata.
//     - Write goes to DONE. Read goes to RDOUT.
//   RDOUT
//     - ram_cs=1, ram_wr_rd=0, ram_out_en=1, same address (re-read is harmless).
//     - Capture ram_data_out into rdata_q at the closing edge; go to DONE.
//   Out-of-range address (addr >= mem_depth)
//     - ACCESS/RDOUT drive ram_cs=0; go straight to DONE with err=1 and rdata=0.
//     - A write is dropped.
//   DONE
//     - Owner's x_done=1 for exactly one cycle; x_rdata/x_err presented; go to IDLE.
//     - The non-owner's done, rdata and err stay 0.
//   Latency from grant cycle to done cycle: write 2, read 3. Back-to-back occupancy: write 3, read 4 cycles.
//   All RAM outputs are registered or state-decoded. Outside ACCESS/RDOUT: ram_cs=0, ram_out_en=0, ram_wr_rd=0.
//   Reset (any cycle, including mid-transaction)
//     - state=IDLE, last_owner=B, all outputs 0, ram_cs=0 immediately.
//     - An in-flight transaction is abandoned with no done pulse; the requester must re-issue.
//   x_req deasserted in the same cycle as grant is still completed; x_req must not drop before gnt.
//   rdata_q holds its value between reads; x_rdata is gated to 0 when x_done=0.
// STRUCTURE
//   spram_ctrl_pkg: state encoding (IDLE/ACCESS/RDOUT/DONE), OWNER_A/OWNER_B constants.
//   Sub-module rr_arbiter2: two-way round-robin winner and last_owner register. Everything else lives in the top.
//   The testbench instantiates single_port_ram with matching parameters behind the arbiter.
// TESTING
//   1. A writes 8'h5A @4, then A reads @4 -> a_done 2 cycles after the write grant; read a_done 3 cycles after its grant with a_rdata=8'h5A, a_err=0.
//   2. A and B both request at once from reset -> A granted first; B granted in the IDLE after A's DONE; then a tie with last_owner=B... repeats alternate A,B,A,B.
//   3. B reads @15 after B writes 8'hC3 @15 -> b_rdata=8'hC3; a_done stays 0 throughout; ram_out_en=1 only in RDOUT.
//   4. mem_depth=12: A writes @13 -> a_done with a_err=1, ram_cs never 1; a following read @13 returns err=1, rdata=0.
//   5. Assert rst during RDOUT of a read -> ram_cs/ram_out_en drop without a clock edge, no a_done; post-reset tie is granted to A.
//   6. Continuous A requests with B idle -> A granted every 3 (write) / 4 (read) cycles; no bubble beyond the FSM's own cycles.

Source files
------------

// File: rtl/spram_ctrl_pkg.sv
// Shared definitions for the single-port RAM arbiter: FSM state encoding and owner tags.
package spram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDOUT  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational winner plus the last_owner register.
module rr_arbiter2
    import spram_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    input  logic update,
    output logic winner_c
);

    logic last_owner;

    // last_owner starts at B so A wins the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_owner <= OWNER_B;
        end else if (update) begin
            last_owner <= winner_c;
        end
    end

    always_comb begin
        winner_c = OWNER_A;
        if (req_a && req_b) begin
            winner_c = (last_owner == OWNER_B) ? OWNER_A : OWNER_B;
        end else if (req_b) begin
            winner_c = OWNER_B;
        end
    end

endmodule

// File: rtl/spram_arbiter.sv
// Shares one single-port RAM between requesters A and B; sequences the RAM pins and
// returns a one-cycle done pulse with read data / range error to the owning requester.
module spram_arbiter
    import spram_ctrl_pkg::*;
#(
    parameter int unsigned data_width = 8,
    parameter int unsigned addr_size  = 4,
    parameter int unsigned mem_depth  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_req,
    input  logic                  a_wr,
    input  logic [addr_size-1:0]  a_addr,
    input  logic [data_width-1:0] a_wdata,
    output logic                  a_gnt,
    output logic                  a_done,
    output logic [data_width-1:0] a_rdata,
    output logic                  a_err,
    input  logic                  b_req,
    input  logic                  b_wr,
    input  logic [addr_size-1:0]  b_addr,
    input  logic [data_width-1:0] b_wdata,
    output logic                  b_gnt,
    output logic                  b_done,
    output logic [data_width-1:0] b_rdata,
    output logic                  b_err,
    output logic                  ram_cs,
    output logic                  ram_wr_rd,
    output logic                  ram_out_en,
    output logic [addr_size-1:0]  ram_address,
    output logic [data_width-1:0] ram_data_in,
    input  logic [data_width-1:0] ram_data_out
);

    state_t                state_q;
    state_t                state_d;
    logic                  winner;
    logic                  grant;
    logic                  done_c;
    logic                  owner_q;
    logic                  wr_q;
    logic                  err_q;
    logic [addr_size-1:0]  addr_q;
    logic [data_width-1:0] wdata_q;
    logic [data_width-1:0] rdata_q;
    logic                  wr_sel;
    logic [addr_size-1:0]  addr_sel;
    logic [data_width-1:0] wdata_sel;

    rr_arbiter2 u_rr (
        .clk      (clk),
        .rst      (rst),
        .req_a    (a_req),
        .req_b    (b_req),
        .update   (grant),
        .winner_c (winner)
    );

    // Grants only from IDLE; masked while reset is asserted so every output is 0 in reset
    assign grant = (state_q == IDLE) && (a_req || b_req) && !rst;
    assign a_gnt = grant && a_req && (winner == OWNER_A);
    assign b_gnt = grant && b_req && (winner == OWNER_B);

    assign wr_sel    = (winner == OWNER_A) ? a_wr    : b_wr;
    assign addr_sel  = (winner == OWNER_A) ? a_addr  : b_addr;
    assign wdata_sel = (winner == OWNER_A) ? a_wdata : b_wdata;

    // Transaction latch; the range check is resolved at grant time
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q <= OWNER_B;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (grant) begin
            owner_q <= winner;
            wr_q    <= wr_sel;
            err_q   <= (32'(addr_sel) >= mem_depth);
            addr_q  <= addr_sel;
            wdata_q <= wdata_sel;
        end
    end

    // Read data is captured at the closing edge of RDOUT and held between reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (state_q == RDOUT) begin
            rdata_q <= ram_data_out;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ram_cs     = 1'b0;
        ram_wr_rd  = 1'b0;
        ram_out_en = 1'b0;
        done_c     = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // Out-of-range accesses never select the RAM and skip RDOUT
                ram_cs    = !err_q;
                ram_wr_rd = wr_q && !err_q;
                state_d   = (wr_q || err_q) ? DONE : RDOUT;
            end
            RDOUT: begin
                ram_cs     = 1'b1;
                ram_out_en = 1'b1;
                state_d    = DONE;
            end
            DONE: begin
                done_c  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ram_address = addr_q;
    assign ram_data_in = wdata_q;

    assign a_done  = done_c && (owner_q == OWNER_A);
    assign b_done  = done_c && (owner_q == OWNER_B);
    assign a_err   = a_done && err_q;
    assign b_err   = b_done && err_q;
    assign a_rdata = (a_done && !wr_q && !err_q) ? rdata_q : '0;
    assign b_rdata = (b_done && !wr_q && !err_q) ? rdata_q : '0;

endmodule

// File: tb/tb_spram_arbiter.sv
// Directed self-checking bench for spram_arbiter with behavioural single-port RAMs behind it.
module tb_spram_arbiter;

    logic clk;
    logic rst;
    int   cyc;
    int   n_cmp;
    int   n_bad;

    // depth-16 instance
    logic       a_req, a_wr, a_gnt, a_done, a_err;
    logic [3:0] a_addr;
    logic [7:0] a_wdata, a_rdata;
    logic       b_req, b_wr, b_gnt, b_done, b_err;
    logic [3:0] b_addr;
    logic [7:0] b_wdata, b_rdata;
    logic       ram_cs, ram_wr_rd, ram_out_en;
    logic [3:0] ram_address;
    logic [7:0] ram_data_in;
    wire  [7:0] ram_data_out;

    // depth-12 instance
    logic       e_a_req, e_a_wr, e_a_gnt, e_a_done, e_a_err;
    logic [3:0] e_a_addr;
    logic [7:0] e_a_wdata, e_a_rdata;
    logic       e_b_req, e_b_wr, e_b_gnt, e_b_done, e_b_err;
    logic [3:0] e_b_addr;
    logic [7:0] e_b_wdata, e_b_rdata;
    logic       e_ram_cs, e_ram_wr_rd, e_ram_out_en;
    logic [3:0] e_ram_address;
    logic [7:0] e_ram_data_in;
    wire  [7:0] e_ram_data_out;

    spram_arbiter #(.data_width(8), .addr_size(4), .mem_depth(16)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_done(a_done), .a_rdata(a_rdata), .a_err(a_err),
        .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_done(b_done), .b_rdata(b_rdata), .b_err(b_err),
        .ram_cs(ram_cs), .ram_wr_rd(ram_wr_rd), .ram_out_en(ram_out_en),
        .ram_address(ram_address), .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
    );

    spram_arbiter #(.data_width(8), .addr_size(4), .mem_depth(12)) dut12 (
        .clk(clk), .rst(rst),
        .a_req(e_a_req), .a_wr(e_a_wr), .a_addr(e_a_addr), .a_wdata(e_a_wdata),
        .a_gnt(e_a_gnt), .a_done(e_a_done), .a_rdata(e_a_rdata), .a_err(e_a_err),
        .b_req(e_b_req), .b_wr(e_b_wr), .b_addr(e_b_addr), .b_wdata(e_b_wdata),
        .b_gnt(e_b_gnt), .b_done(e_b_done), .b_rdata(e_b_rdata), .b_err(e_b_err),
        .ram_cs(e_ram_cs), .ram_wr_rd(e_ram_wr_rd), .ram_out_en(e_ram_out_en),
        .ram_address(e_ram_address), .ram_data_in(e_ram_data_in), .ram_data_out(e_ram_data_out)
    );

    // Single-port RAM models: synchronous write, registered read, tristated data_out
    logic [7:0] mem   [16];
    logic [7:0] e_mem [16];
    logic [7:0] ram_q, e_ram_q;

    always @(posedge clk) begin
        if (ram_cs && ram_wr_rd)  mem[ram_address] <= ram_data_in;
        if (ram_cs && !ram_wr_rd) ram_q <= mem[ram_address];
        if (e_ram_cs && e_ram_wr_rd)  e_mem[e_ram_address] <= e_ram_data_in;
        if (e_ram_cs && !e_ram_wr_rd) e_ram_q <= e_mem[e_ram_address];
    end

    assign ram_data_out   = (ram_cs && ram_out_en && !ram_wr_rd) ? ram_q : 8'bz;
    assign e_ram_data_out = (e_ram_cs && e_ram_out_en && !e_ram_wr_rd) ? e_ram_q : 8'bz;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to have finished", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic drive(input bit on12, input bit is_b, input logic req, input logic wr,
                         input logic [3:0] addr, input logic [7:0] wd);
        if (on12) begin
            e_a_req = req; e_a_wr = wr; e_a_addr = addr; e_a_wdata = wd;
        end else if (is_b) begin
            b_req = req; b_wr = wr; b_addr = addr; b_wdata = wd;
        end else begin
            a_req = req; a_wr = wr; a_addr = addr; a_wdata = wd;
        end
    endtask

    // Issues one transaction and reports latency, returned data and RAM pin activity
    task automatic run_txn(input bit on12, input bit is_b, input logic wr, input logic [3:0] addr,
                           input logic [7:0] wd, output int lat, output logic [7:0] rd,
                           output logic er, output int cs_cnt, output int oe_cnt,
                           output int oe_pos, output bit other_done);
        int   g;
        int   n;
        logic gnt_o, done_o, cs_o, oe_o, oth_o;
        lat = -1; rd = '0; er = 1'b0; cs_cnt = 0; oe_cnt = 0; oe_pos = -1; other_done = 1'b0;
        @(negedge clk);
        drive(on12, is_b, 1'b1, wr, addr, wd);
        #1;
        n = 0;
        gnt_o = on12 ? e_a_gnt : (is_b ? b_gnt : a_gnt);
        while (!gnt_o && n < 20) begin
            @(negedge clk); #1; n++;
            gnt_o = on12 ? e_a_gnt : (is_b ? b_gnt : a_gnt);
        end
        if (!gnt_o) begin
            drive(on12, is_b, 1'b0, wr, addr, wd);
            return;
        end
        g = cyc;
        @(negedge clk);
        drive(on12, is_b, 1'b0, wr, addr, wd);
        n = 0;
        while (n < 10) begin
            cs_o   = on12 ? e_ram_cs     : ram_cs;
            oe_o   = on12 ? e_ram_out_en : ram_out_en;
            done_o = on12 ? e_a_done : (is_b ? b_done : a_done);
            oth_o  = on12 ? e_b_done : (is_b ? a_done : b_done);
            if (cs_o) cs_cnt++;
            if (oe_o) begin oe_cnt++; oe_pos = cyc - g; end
            if (oth_o) other_done = 1'b1;
            if (done_o) begin
                lat = cyc - g;
                rd  = on12 ? e_a_rdata : (is_b ? b_rdata : a_rdata);
                er  = on12 ? e_a_err   : (is_b ? b_err   : a_err);
                break;
            end
            @(negedge clk); n++;
        end
    endtask

    task automatic test_reset();
        logic [31:0] outs;
        rst = 1'b1;
        a_req = 1'b1; b_req = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if ({a_gnt, b_gnt} !== 2'b00) begin
            n_bad++; $display("FAIL reset_gnt: got %b expected 00", {a_gnt, b_gnt});
        end
        outs = {a_done, a_err, a_rdata, b_done, b_err, b_rdata, ram_cs, ram_wr_rd, ram_out_en};
        n_cmp++;
        if (outs !== 32'h0 || ram_address !== 4'h0 || ram_data_in !== 8'h0) begin
            n_bad++; $display("FAIL reset_outputs: got %h/%h/%h expected all zero", outs, ram_address, ram_data_in);
        end
        a_req = 1'b0; b_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({a_done, b_done, ram_cs, ram_out_en, ram_wr_rd} !== 5'b0) begin
            n_bad++; $display("FAIL idle_outputs: got %b expected 00000", {a_done, b_done, ram_cs, ram_out_en, ram_wr_rd});
        end
    endtask

    task automatic test_tie_alternation();
        logic [1:0] exp_g, exp_d;
        @(negedge clk);
        a_req = 1'b1; a_wr = 1'b1; a_addr = 4'd1; a_wdata = 8'h11;
        b_req = 1'b1; b_wr = 1'b1; b_addr = 4'd2; b_wdata = 8'h22;
        for (int k = 0; k < 12; k++) begin
            #1;
            exp_g = (k % 6 == 0) ? 2'b10 : ((k % 6 == 3) ? 2'b01 : 2'b00);
            exp_d = (k % 6 == 2) ? 2'b10 : ((k % 6 == 5) ? 2'b01 : 2'b00);
            n_cmp++;
            if ({a_gnt, b_gnt} !== exp_g) begin
                n_bad++; $display("FAIL tie_gnt[%0d]: got %b expected %b", k, {a_gnt, b_gnt}, exp_g);
            end
            n_cmp++;
            if ({a_done, b_done} !== exp_d) begin
                n_bad++; $display("FAIL tie_done[%0d]: got %b expected %b", k, {a_done, b_done}, exp_d);
            end
            @(negedge clk);
        end
        a_req = 1'b0; b_req = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_a_write_read();
        int lat, cs_cnt, oe_cnt, oe_pos; logic [7:0] rd; logic er; bit oth;
        run_txn(1'b0, 1'b0, 1'b1, 4'd4, 8'h5A, lat, rd, er, cs_cnt, oe_cnt, oe_pos, oth);
        n_cmp++;
        if (lat !== 2 || er !== 1'b0 || cs_cnt !== 1 || oe_cnt !== 0) begin
            n_bad++; $display("FAIL a_write: lat=%0d err=%b cs=%0d oe=%0d expected 2/0/1/0", lat, er, cs_cnt, oe_cnt);
        end
        run_txn(1'b0, 1'b0, 1'b0, 4'd4, 8'h00, lat, rd, er, cs_cnt, oe_cnt, oe_pos, oth);
        n_cmp++;
        if (lat !== 3) begin
            n_bad++; $display("FAIL a_read_lat: got %0d expected 3", lat);
        end
        n_cmp++;
        if (rd !== 8'h5A || er !== 1'b0) begin
            n_bad++; $display("FAIL a_read_data: got %h err=%b expected 5a err=0", rd, er);
        end
        n_cmp++;
        if (cs_cnt !== 2 || oth !== 1'b0) begin
            n_bad++; $display("FAIL a_read_pins: cs=%0d b_done=%b expected 2/0", cs_cnt, oth);
        end
    endtask

    task automatic test_b_write_read();
        int lat, cs_cnt, oe_cnt, oe_pos; logic [7:0] rd; logic er; bit oth;
        run_txn(1'b0, 1'b1, 1'b1, 4'd15, 8'hC3, lat, rd, er, cs_cnt, oe_cnt, oe_pos, oth);
        n_cmp++;
        if (lat !== 2 || er !== 1'b0 || oth !== 1'b0 || oe_cnt !== 0) begin
            n_bad++; $display("FAIL b_write: lat=%0d err=%b a_done=%b oe=%0d expected 2/0/0/0", lat, er, oth, oe_cnt);
        end
        run_txn(1'b0, 1'b1, 1'b0, 4'd15, 8'h00, lat, rd, er, cs_cnt, oe_cnt, oe_pos, oth);
        n_cmp++;
        if (lat !== 3 || rd !== 8'hC3 || er !== 1'b0) begin
            n_bad++; $display("FAIL b_read: lat=%0d data=%h err=%b expected 3/c3/0", lat, rd, er);
        end
        n_cmp++;
        if (oth !== 1'b0) begin
            n_bad++; $display("FAIL b_read_a_done: got %b expected 0", oth);
        end
        n_cmp++;
        if (oe_cnt !== 1 || oe_pos !== 2) begin
            n_bad++; $display("FAIL b_read_out_en: count=%0d pos=%0d expected 1/2", oe_cnt, oe_pos);
        end
    endtask

    task automatic test_out_of_range();
        int lat, cs_cnt, oe_cnt, oe_pos; logic [7:0] rd; logic er; bit oth;
        run_txn(1'b1, 1'b0, 1'b1, 4'd11, 8'h77, lat, rd, er, cs_cnt, oe_cnt, oe_pos, oth);
        n_cmp++;
        if (lat !== 2 || er !== 1'b0 || cs_cnt !== 1) begin
            n_bad++; $display("FAIL edge_write11: lat=%0d err=%b cs=%0d expected 2/0/1", lat, er, cs_cnt);
        end
        run_txn(1'b1, 1'b0, 1'b0, 4'd11, 8'h00, lat, rd, er, cs_cnt, oe_cnt, oe_pos, oth);
        n_cmp++;
        if (lat !== 3 || rd !== 8'h77 || er !== 1'b0) begin
            n_bad++; $display("FAIL edge_read11: lat=%0d data=%h err=%b expected 3/77/0", lat, rd, er);
        end
        run_txn(1'b1, 1'b0, 1'b1, 4'd13, 8'hEE, lat, rd, er, cs_cnt, oe_cnt, oe_pos, oth);
        n_cmp++;
        if (lat !== 2 || er !== 1'b1 || cs_cnt !== 0) begin
            n_bad++; $display("FAIL oor_write13: lat=%0d err=%b cs=%0d expected 2/1/0", lat, er, cs_cnt);
        end
        run_txn(1'b1, 1'b0, 1'b0, 4'd13, 8'h00, lat, rd, er, cs_cnt, oe_cnt, oe_pos, oth);
        n_cmp++;
        if (lat !== 2 || er !== 1'b1 || rd !== 8'h00) begin
            n_bad++; $display("FAIL oor_read13: lat=%0d err=%b data=%h expected 2/1/00", lat, er, rd);
        end
        n_cmp++;
        if (cs_cnt !== 0 || oe_cnt !== 0) begin
            n_bad++; $display("FAIL oor_read_pins: cs=%0d oe=%0d expected 0/0", cs_cnt, oe_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_g, exp_d;
        @(negedge clk);
        a_req = 1'b1; a_wr = 1'b1; a_addr = 4'd4; a_wdata = 8'h5A;
        for (int k = 0; k < 21; k++) begin
            if (k == 9) a_wr = 1'b0;
            #1;
            exp_g = (k < 9) ? (k % 3 == 0) : ((k - 9) % 4 == 0);
            exp_d = (k < 9) ? (k % 3 == 2) : ((k - 9) % 4 == 3);
            n_cmp++;
            if (a_gnt !== exp_g) begin
                n_bad++; $display("FAIL b2b_gnt[%0d]: got %b expected %b", k, a_gnt, exp_g);
            end
            n_cmp++;
            if (a_done !== exp_d) begin
                n_bad++; $display("FAIL b2b_done[%0d]: got %b expected %b", k, a_done, exp_d);
            end
            if (k >= 9 && exp_d) begin
                n_cmp++;
                if (a_rdata !== 8'h5A) begin
                    n_bad++; $display("FAIL b2b_rdata[%0d]: got %h expected 5a", k, a_rdata);
                end
            end
            @(negedge clk);
        end
        a_req = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid_read();
        bit saw_done;
        @(negedge clk);
        a_req = 1'b1; a_wr = 1'b0; a_addr = 4'd4;
        #1;
        n_cmp++;
        if (a_gnt !== 1'b1) begin
            n_bad++; $display("FAIL rst_mid_gnt: got %b expected 1", a_gnt);
        end
        @(negedge clk);
        a_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({ram_cs, ram_out_en} !== 2'b11) begin
            n_bad++; $display("FAIL rst_mid_rdout: got %b expected 11", {ram_cs, ram_out_en});
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({ram_cs, ram_out_en} !== 2'b00) begin
            n_bad++; $display("FAIL rst_mid_drop: got %b expected 00", {ram_cs, ram_out_en});
        end
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (a_done) saw_done = 1'b1;
            @(negedge clk);
        end
        n_cmp++;
        if (saw_done !== 1'b0) begin
            n_bad++; $display("FAIL rst_mid_no_done: got %b expected 0", saw_done);
        end
        a_req = 1'b1; a_wr = 1'b1; a_addr = 4'd0; a_wdata = 8'h01;
        b_req = 1'b1; b_wr = 1'b1; b_addr = 4'd3; b_wdata = 8'h03;
        #1;
        n_cmp++;
        if ({a_gnt, b_gnt} !== 2'b10) begin
            n_bad++; $display("FAIL rst_tie: got %b expected 10", {a_gnt, b_gnt});
        end
        @(negedge clk);
        a_req = 1'b0; b_req = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0;
        rst = 1'b1;
        a_req = 1'b0; a_wr = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdata = '0;
        e_a_req = 1'b0; e_a_wr = 1'b0; e_a_addr = '0; e_a_wdata = '0;
        e_b_req = 1'b0; e_b_wr = 1'b0; e_b_addr = '0; e_b_wdata = '0;
        test_reset();
        test_tie_alternation();
        test_a_write_read();
        test_b_write_read();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
